inst_fetch_mem: RTL and testbench

INST_FETCH_MEM -- requirements
Module: inst_fetch_mem

---
 rtl/inst_fetch_mem.sv | 95 +++++++++
 tb/tb_inst_fetch_mem.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_mem.sv
// Instruction memory with a one-cycle registered fetch port, range/alignment fault detection and a program-load write port.
// A request accepted at edge N is visible after edge N; stall freezes the output registers and drops that cycle's request.
module inst_fetch_mem #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 9,
  parameter logic [31:0]           BASE_ADDR  = 32'h00400000,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           pc,
  input  logic                  fetch_req,
  input  logic                  stall,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] inst,
  output logic                  inst_valid,
  output logic                  addr_fault,
  output logic [15:0]           fault_count,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_wdata
);

  localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [31:0] SPAN     = 32'(DEPTH) * 32'd4;
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic [31:0]           offset;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  in_range;
  logic                  rd_en;

  logic                  inst_valid_d, inst_valid_q;
  logic                  addr_fault_d, addr_fault_q;
  logic [15:0]           fault_count_d, fault_count_q;

  // Offset is taken modulo 2^32; the lower-bound check guards the wrap case.
  assign offset   = pc - BASE_ADDR;
  assign rd_idx   = offset[ADDR_WIDTH+1:2];
  assign in_range = (pc >= BASE_ADDR) && (offset < SPAN) && (pc[1:0] == 2'b00);

  always_comb begin
    inst_valid_d  = inst_valid_q;
    addr_fault_d  = addr_fault_q;
    fault_count_d = fault_count_q;
    rd_en         = 1'b0;
    if (!stall) begin
      inst_valid_d = 1'b0;
      addr_fault_d = 1'b0;
      if (!flush && fetch_req) begin
        if (in_range) begin
          inst_valid_d = 1'b1;
          rd_en        = 1'b1;
        end else begin
          addr_fault_d = 1'b1;
          if (fault_count_q != CNT_MAX) begin
            fault_count_d = fault_count_q + 16'd1;
          end
        end
      end
    end
  end

  // Single read and single write port in one block: read-first and block-RAM friendly.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem_q[prog_addr] <= prog_wdata;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inst_valid_q  <= 1'b0;
      addr_fault_q  <= 1'b0;
      fault_count_q <= 16'd0;
    end else begin
      inst_valid_q  <= inst_valid_d;
      addr_fault_q  <= addr_fault_d;
      fault_count_q <= fault_count_d;
    end
  end

  // The read register is only meaningful while valid; otherwise present the NOP word.
  assign inst        = inst_valid_q ? rd_data_q : NOP_WORD;
  assign inst_valid  = inst_valid_q;
  assign addr_fault  = addr_fault_q;
  assign fault_count = fault_count_q;

endmodule

// File: tb/tb_inst_fetch_mem.sv
module tb_inst_fetch_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        fetch_req;
  logic        stall;
  logic        flush;
  logic [31:0] inst;
  logic        inst_valid;
  logic        addr_fault;
  logic [15:0] fault_count;
  logic        prog_we;
  logic [8:0]  prog_addr;
  logic [31:0] prog_wdata;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  inst_fetch_mem dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .fetch_req  (fetch_req),
    .stall      (stall),
    .flush      (flush),
    .inst       (inst),
    .inst_valid (inst_valid),
    .addr_fault (addr_fault),
    .fault_count(fault_count),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e_inst, input logic e_vld,
                         input logic e_flt, input logic [15:0] e_cnt);
    chk({tag, ".inst"},  inst,        e_inst);
    chk({tag, ".vld"},   {31'd0, inst_valid}, {31'd0, e_vld});
    chk({tag, ".fault"}, {31'd0, addr_fault}, {31'd0, e_flt});
    chk({tag, ".cnt"},   {16'd0, fault_count}, {16'd0, e_cnt});
  endtask

  task automatic prog(input logic [8:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] addr);
    fetch_req = 1'b1; pc = addr;
    tick();
    fetch_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pc = 32'h0; fetch_req = 1'b0; stall = 1'b0; flush = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    tick(); tick();
    chk_out("reset", 32'h0, 1'b0, 1'b0, 16'd0);
    reset = 1'b0;

    prog(9'd0,   32'h24100000);
    prog(9'd1,   32'h24110000);
    prog(9'd5,   32'h00000000);
    prog(9'd511, 32'h11223344);

    // Back-to-back fetches, one-cycle latency
    fetch_req = 1'b1; pc = 32'h00400000; tick();
    chk_out("f0", 32'h24100000, 1'b1, 1'b0, 16'd0);
    pc = 32'h00400004; tick();
    chk_out("f1", 32'h24110000, 1'b1, 1'b0, 16'd0);
    fetch_req = 1'b0; tick();
    chk_out("idle", 32'h0, 1'b0, 1'b0, 16'd0);

    // Last word in range, then the three fault classes
    fetch(32'h004007FC);
    chk_out("last", 32'h11223344, 1'b1, 1'b0, 16'd0);
    fetch(32'h00400800);
    chk_out("hi", 32'h0, 1'b0, 1'b1, 16'd1);
    fetch(32'h003FFFFC);
    chk_out("lo", 32'h0, 1'b0, 1'b1, 16'd2);
    fetch(32'h00400002);
    chk_out("mis", 32'h0, 1'b0, 1'b1, 16'd3);

    // Stall holds outputs while pc moves, and beats flush
    fetch(32'h00400000);
    chk_out("pre", 32'h24100000, 1'b1, 1'b0, 16'd3);
    stall = 1'b1; fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc = 32'h00400004 + 32'(i * 4);
      tick();
      chk_out("stall", 32'h24100000, 1'b1, 1'b0, 16'd3);
    end
    flush = 1'b1; tick();
    chk_out("stfl", 32'h24100000, 1'b1, 1'b0, 16'd3);
    stall = 1'b0; pc = 32'h00400000; tick();
    chk_out("flush", 32'h0, 1'b0, 1'b0, 16'd3);
    flush = 1'b0; fetch_req = 1'b0;

    // Faulted output held under stall without recounting
    fetch(32'h00400801);
    chk_out("flt4", 32'h0, 1'b0, 1'b1, 16'd4);
    stall = 1'b1; fetch_req = 1'b1; pc = 32'h00500000; tick();
    chk_out("stflt", 32'h0, 1'b0, 1'b1, 16'd4);
    stall = 1'b0; fetch_req = 1'b0;

    // Read-first collision
    prog_we = 1'b1; prog_addr = 9'd5; prog_wdata = 32'hDEADBEEF;
    fetch(32'h00400014);
    prog_we = 1'b0;
    chk_out("rdfirst", 32'h0, 1'b1, 1'b0, 16'd4);
    fetch(32'h00400014);
    chk_out("rdnew", 32'hDEADBEEF, 1'b1, 1'b0, 16'd4);

    // Program write is independent of stall
    stall = 1'b1; prog(9'd2, 32'hCAFEF00D); stall = 1'b0;
    fetch(32'h00400008);
    chk_out("stwr", 32'hCAFEF00D, 1'b1, 1'b0, 16'd4);

    // Mid-stream reset with a fetch and a write in the same cycle
    fetch(32'h00400004);
    chk_out("prerst", 32'h24110000, 1'b1, 1'b0, 16'd4);
    reset = 1'b1; fetch_req = 1'b1; pc = 32'h00400000;
    prog_we = 1'b1; prog_addr = 9'd3; prog_wdata = 32'hA5A5A5A5;
    tick();
    chk_out("rst", 32'h0, 1'b0, 1'b0, 16'd0);
    reset = 1'b0; fetch_req = 1'b0; prog_we = 1'b0; tick();
    chk_out("postrst", 32'h0, 1'b0, 1'b0, 16'd0);
    fetch(32'h00400000);
    chk_out("mem0", 32'h24100000, 1'b1, 1'b0, 16'd0);
    fetch(32'h0040000C);
    chk_out("rstwr", 32'hA5A5A5A5, 1'b1, 1'b0, 16'd0);

    // Saturating fault counter
    fetch_req = 1'b1; pc = 32'h00400002;
    for (int i = 0; i < 65534; i++) tick();
    chk_out("cntfe", 32'h0, 1'b0, 1'b1, 16'hFFFE);
    tick();
    chk_out("cntff", 32'h0, 1'b0, 1'b1, 16'hFFFF);
    tick();
    chk_out("cntsat", 32'h0, 1'b0, 1'b1, 16'hFFFF);
    fetch_req = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
